// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_flex family of single-clock queues.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Bits needed to count 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// Simple dual-port storage for fifo_flex: synchronous write, asynchronous read.
module fifo_flex_ram #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // NOTE: storage has no reset; validity is tracked by the pointers and level,
  // and leaving it out keeps the array mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO with registered or fall-through read,
// fill-level flags, synchronous flush and sticky overflow/underflow.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 9,
  parameter int DEPTH_LOG2   = 6,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = (2**DEPTH_LOG2) - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                                  clk,
  input  logic                                  rstp,
  input  logic                                  clear,
  input  logic                                  wr_en,
  input  logic [WIDTH-1:0]                      wr_data,
  input  logic                                  rd_en,
  output logic [WIDTH-1:0]                      rd_data,
  output logic                                  rd_valid,
  output logic                                  empty,
  output logic                                  full,
  output logic                                  almost_empty,
  output logic                                  almost_full,
  output logic [level_width(2**DEPTH_LOG2)-1:0] level,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int         DEPTH = 2**DEPTH_LOG2;
  localparam int         LW    = level_width(DEPTH);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [LW-1:0]         DEPTH_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0]         AFULL_LVL  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0]         AEMPTY_LVL = LW'(AEMPTY_LEVEL);
  localparam logic [LW-1:0]         LVL_ONE    = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  if (DEPTH_LOG2 < 1 || AEMPTY_LEVEL <= 0 || AEMPTY_LEVEL >= AFULL_LEVEL
      || AFULL_LEVEL > DEPTH) begin : g_bad_params
    $fatal(1, "fifo_flex: illegal DEPTH_LOG2/AEMPTY_LEVEL/AFULL_LEVEL combination");
  end

  logic [DEPTH_LOG2-1:0] head, tail;
  logic [LW-1:0]         level_q;
  logic                  overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;
  logic [WIDTH-1:0]      mem_rd;

  // Flags come from registered level only, so no request-to-flag path exists.
  assign empty        = (level_q == '0);
  assign full         = (level_q == DEPTH_LVL);
  assign almost_empty = (level_q <= AEMPTY_LVL);
  assign almost_full  = (level_q >= AFULL_LVL);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_flex_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~clear),
    .waddr (head),
    .wdata (wr_data),
    .raddr (tail),
    .rdata (mem_rd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      head        <= '0;
      tail        <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      head        <= '0;
      tail        <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) head <= head + PTR_ONE;
      if (rd_acc) tail <= tail + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      if (wr_en && full)  overflow_q  <= 1'b1;
      if (rd_en && empty) underflow_q <= 1'b1;
    end
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head-of-queue word is shown directly; forced to zero while nothing is held.
    assign rd_data  = empty ? '0 : mem_rd;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (clear) begin
        rd_valid_q <= 1'b0;
      end else if (rd_acc) begin
        rd_data_q  <= mem_rd;
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: a registered-read instance driven from a vector
// table plus hand-written wrap/reset sequences, and a fall-through instance.
module tb_fifo_flex;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rstp;
  always #5 clk = ~clk;

  // Registered-read instance
  logic       clear, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] level;

  // Fall-through instance
  logic       f_clear, f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_empty, f_full, f_almost_empty, f_almost_full;
  logic       f_overflow, f_underflow;
  logic [2:0] f_level;

  fifo_flex #(.WIDTH(8), .DEPTH_LOG2(2), .FWFT(0), .AFULL_LEVEL(2), .AEMPTY_LEVEL(1)) dut (
    .clk(clk), .rstp(rstp), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  fifo_flex #(.WIDTH(8), .DEPTH_LOG2(2), .FWFT(1), .AFULL_LEVEL(2), .AEMPTY_LEVEL(1)) dut_fw (
    .clk(clk), .rstp(rstp), .clear(f_clear), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
    .full(f_full), .almost_empty(f_almost_empty), .almost_full(f_almost_full),
    .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and land 1 ns after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic r, input logic [7:0] d);
    clear   = c;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
  endtask

  typedef struct {
    logic       clr, wr, rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rv, emp, ful, ae, af;
    logic [2:0] lvl;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check_std(input string tag, input vec_t v);
    check({tag, ".rd_data"},      rd_data,      v.dout);
    check({tag, ".rd_valid"},     rd_valid,     v.rv);
    check({tag, ".empty"},        empty,        v.emp);
    check({tag, ".full"},         full,         v.ful);
    check({tag, ".almost_empty"}, almost_empty, v.ae);
    check({tag, ".almost_full"},  almost_full,  v.af);
    check({tag, ".level"},        level,        v.lvl);
    check({tag, ".overflow"},     overflow,     v.ovf);
    check({tag, ".underflow"},    underflow,    v.unf);
  endtask

  initial begin
    vec_t rst_v;
    logic [7:0] d0, d1;

    //                 clr   wr    rd    din     dout   rv    emp   ful   ae    af    lvl   ovf   unf
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    // Empty: write accepted, read rejected
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h5A, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h01, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h02, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h03, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h04, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0});
    // Full: read accepted, write rejected
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h99, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1});
    // Level 3 with errors set, then clear together with a write
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hA0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hA1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hA2, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hB0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hC0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});

    rst_v = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

    rstp = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    f_clear = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;
    tick();
    tick();
    check_std("reset", rst_v);
    @(negedge clk);
    rstp = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
      tick();
      check_std($sformatf("vec%0d", i), vecs[i]);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Ten write-2/read-2 rounds walk the pointers around the 4-entry ring several times.
    for (int r = 0; r < 10; r++) begin
      d0 = 8'(8'h80 + 2 * r);
      d1 = 8'(8'h81 + 2 * r);
      drive(1'b0, 1'b1, 1'b0, d0); tick();
      drive(1'b0, 1'b1, 1'b0, d1); tick();
      check($sformatf("wrap%0d.level_after_writes", r), level, 3'd2);
      drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
      check($sformatf("wrap%0d.first", r), rd_data, d0);
      drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
      check($sformatf("wrap%0d.second", r), rd_data, d1);
      check($sformatf("wrap%0d.valid", r), rd_valid, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
    check("wrap.level_end", level, 3'd0);
    check("wrap.empty_end", empty, 1'b1);
    check("wrap.overflow", overflow, 1'b0);
    check("wrap.underflow", underflow, 1'b0);

    // Fill, overflow, pop one, then async reset between edges.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(8'hE0 + i)); tick();
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
    check("pre_rst.rd_data", rd_data, 8'hE0);
    check("pre_rst.overflow", overflow, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rstp = 1'b1;
    #1;
    check_std("async_rst", rst_v);
    @(negedge clk);
    rstp = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 8'h77); tick();
    check("post_rst.level", level, 3'd1);
    drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
    check("post_rst.rd_data", rd_data, 8'h77);
    check("post_rst.rd_valid", rd_valid, 1'b1);
    check("post_rst.empty", empty, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Fall-through instance (reset just above as well).
    check("fw.reset_empty", f_empty, 1'b1);
    check("fw.reset_valid", f_rd_valid, 1'b0);
    check("fw.reset_data", f_rd_data, 8'h00);
    f_wr_en = 1'b1; f_wr_data = 8'hA5; tick();
    f_wr_en = 1'b0;
    check("fw.show_data", f_rd_data, 8'hA5);
    check("fw.show_valid", f_rd_valid, 1'b1);
    check("fw.level1", f_level, 3'd1);
    f_rd_en = 1'b1; tick();
    f_rd_en = 1'b0;
    check("fw.pop_empty", f_empty, 1'b1);
    check("fw.pop_valid", f_rd_valid, 1'b0);
    f_wr_en = 1'b1; f_wr_data = 8'hB1; tick();
    f_wr_data = 8'hB2; tick();
    f_wr_en = 1'b0;
    check("fw.head_b1", f_rd_data, 8'hB1);
    f_rd_en = 1'b1; tick();
    check("fw.head_b2", f_rd_data, 8'hB2);
    check("fw.valid_b2", f_rd_valid, 1'b1);
    tick();
    f_rd_en = 1'b0;
    check("fw.drained", f_empty, 1'b1);
    check("fw.underflow", f_underflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
